// File: rtl/img_rsz_pxl_fwd.sv
// Forward end of the image resizer: buffers resized pixels, streams them out with
// resized-image coordinates, and generates FwdNum/FrmDone feedback for the capturer.
module img_rsz_pxl_fwd #(
    parameter int    RSZ_IMG_WIDTH_SIZE  = 32,
    parameter int    RSZ_IMG_HEIGHT_SIZE = 32,
    parameter int    RSZ_X_W             = 5,
    parameter int    RSZ_Y_W             = 5,
    parameter int    PXL_PRIM_COLOR_NUM  = 3,
    parameter int    PXL_PRIM_COLOR_W    = 8,
    parameter string RSZ_PXL_FWD_TYP     = "ROW",
    parameter int    RSZ_PXL_FWD_CNT_W   = 6,
    parameter int    FIFO_DEPTH          = 4
) (
    input  logic                                                 Clk,
    input  logic                                                 Reset,
    input  logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0]  RszPxlData,
    input  logic                                                 RszPxlVld,
    output logic                                                 RszPxlRdy,
    output logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0]  OutPxlData,
    output logic [RSZ_X_W-1:0]                                   OutPxlX,
    output logic [RSZ_Y_W-1:0]                                   OutPxlY,
    output logic                                                 OutPxlLast,
    output logic                                                 OutPxlVld,
    input  logic                                                 OutPxlRdy,
    output logic [RSZ_PXL_FWD_CNT_W:0]                           FwdNum,
    output logic                                                 FrmDone,
    output logic                                                 Busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [RSZ_X_W-1:0] X_MAX = RSZ_X_W'(RSZ_IMG_WIDTH_SIZE - 1);
    localparam logic [RSZ_Y_W-1:0] Y_MAX = RSZ_Y_W'(RSZ_IMG_HEIGHT_SIZE - 1);
    localparam bit COL_MODE = (RSZ_PXL_FWD_TYP == "COL");
    localparam bit PXL_MODE = (RSZ_PXL_FWD_TYP == "PXL");

    typedef logic [PXL_PRIM_COLOR_NUM-1:0][PXL_PRIM_COLOR_W-1:0] pxl_t;
    typedef enum logic {IDLE, BUSY} state_t;

    pxl_t               mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [RSZ_X_W-1:0] x;
    logic [RSZ_Y_W-1:0] y;
    state_t             state;
    logic               fwd_q;
    logic               frm_done_q;

    logic empty, full, push, pop, x_end, y_end, last, fwd_unit;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = RszPxlVld && !full;
    assign pop   = !empty && OutPxlRdy;

    assign x_end = (x == X_MAX);
    assign y_end = (y == Y_MAX);
    assign last  = x_end && y_end;

    always_comb begin
        fwd_unit = x_end;
        if (PXL_MODE)
            fwd_unit = 1'b1;
        else if (COL_MODE)
            fwd_unit = y_end;
    end

    // NOTE: pixel storage has no reset; a pointer reset alone empties the buffer,
    // so clearing the array would only cost reset fan-out.
    always_ff @(posedge Clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= RszPxlData;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            x          <= '0;
            y          <= '0;
            fwd_q      <= 1'b0;
            frm_done_q <= 1'b0;
            state      <= IDLE;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            fwd_q      <= pop && fwd_unit;
            frm_done_q <= pop && last;

            // Coordinates track the head pixel, so they only move on a pop.
            if (pop) begin
                if (last) begin
                    x <= '0;
                    y <= '0;
                end else if (COL_MODE) begin
                    if (y_end) begin
                        y <= '0;
                        x <= x + 1'b1;
                    end else begin
                        y <= y + 1'b1;
                    end
                end else begin
                    if (x_end) begin
                        x <= '0;
                        y <= y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
            end

            // A push coinciding with the final pop means the next frame has begun.
            case (state)
                IDLE:    if (push) state <= BUSY;
                BUSY:    if (pop && last && !push) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign RszPxlRdy  = !full;
    assign OutPxlVld  = !empty;
    assign OutPxlData = mem[rd_ptr[AW-1:0]];
    assign OutPxlX    = x;
    assign OutPxlY    = y;
    assign OutPxlLast = last;
    assign FwdNum     = {{RSZ_PXL_FWD_CNT_W{1'b0}}, fwd_q};
    assign FrmDone    = frm_done_q;
    assign Busy       = (state == BUSY);

endmodule

// File: tb/tb_img_rsz_pxl_fwd.sv
// Self-checking bench: PXL, ROW and COL instances share one stimulus stream and are
// compared every cycle against a frame-position reference model.
module tb_img_rsz_pxl_fwd;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int DEPTH = 4;
    localparam int NPIX  = W * H;

    typedef logic [2:0][7:0] pxl_t;

    logic clk = 1'b0;
    logic reset;
    pxl_t rsz_data;
    logic rsz_vld;
    logic out_rdy;

    logic [2:0] rdy_o, vld_o, last_o, done_o, busy_o;
    pxl_t       data_o [3];
    logic [1:0] x_o    [3];
    logic [0:0] y_o    [3];
    logic [6:0] fwd_o  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        img_rsz_pxl_fwd #(
            .RSZ_IMG_WIDTH_SIZE (W),
            .RSZ_IMG_HEIGHT_SIZE(H),
            .RSZ_X_W            (2),
            .RSZ_Y_W            (1),
            .PXL_PRIM_COLOR_NUM (3),
            .PXL_PRIM_COLOR_W   (8),
            .RSZ_PXL_FWD_TYP    (g == 0 ? "PXL" : (g == 1 ? "ROW" : "COL")),
            .RSZ_PXL_FWD_CNT_W  (6),
            .FIFO_DEPTH         (DEPTH)
        ) dut (
            .Clk       (clk),
            .Reset     (reset),
            .RszPxlData(rsz_data),
            .RszPxlVld (rsz_vld),
            .RszPxlRdy (rdy_o[g]),
            .OutPxlData(data_o[g]),
            .OutPxlX   (x_o[g]),
            .OutPxlY   (y_o[g]),
            .OutPxlLast(last_o[g]),
            .OutPxlVld (vld_o[g]),
            .OutPxlRdy (out_rdy),
            .FwdNum    (fwd_o[g]),
            .FrmDone   (done_o[g]),
            .Busy      (busy_o[g])
        );
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: buffer contents, position of the head pixel in the frame,
    // frame-in-progress flag, and the feedback due this cycle per mode.
    pxl_t q[$];
    int   k;
    bit   busy_m;
    bit   fwd_m [3];
    bit   done_m;
    int   fwd_sum [3];
    int   done_sum [3];

    // Feedback unit completed by popping frame position p in mode m (0=PXL,1=ROW,2=COL).
    function automatic bit unit_done(int m, int p);
        if (m == 0) return 1'b1;
        if (m == 1) return (p % W) == W - 1;
        return (p % H) == H - 1;
    endfunction

    function automatic int coord_x(int m, int p);
        return (m == 2) ? p / H : p % W;
    endfunction

    function automatic int coord_y(int m, int p);
        return (m == 2) ? p % H : p / W;
    endfunction

    task automatic check_outputs();
        for (int m = 0; m < 3; m++) begin
            check($sformatf("rdy m%0d", m), 32'(rdy_o[m]), 32'(q.size() < DEPTH));
            check($sformatf("vld m%0d", m), 32'(vld_o[m]), 32'(q.size() > 0));
            check($sformatf("busy m%0d", m), 32'(busy_o[m]), 32'(busy_m));
            check($sformatf("fwd m%0d", m), 32'(fwd_o[m]), 32'(fwd_m[m]));
            check($sformatf("done m%0d", m), 32'(done_o[m]), 32'(done_m));
            fwd_sum[m]  += int'(fwd_o[m]);
            done_sum[m] += int'(done_o[m]);
            if (q.size() > 0) begin
                check($sformatf("data m%0d", m), 32'(data_o[m]), 32'(q[0]));
                check($sformatf("x m%0d", m), 32'(x_o[m]), 32'(coord_x(m, k)));
                check($sformatf("y m%0d", m), 32'(y_o[m]), 32'(coord_y(m, k)));
                check($sformatf("last m%0d", m), 32'(last_o[m]), 32'(k == NPIX - 1));
            end
        end
    endtask

    // One clock cycle: check current outputs, apply inputs, advance the model.
    task automatic step(input logic vld, input pxl_t d, input logic rdy, input logic rst);
        bit do_push, do_pop;
        @(negedge clk);
        check_outputs();
        rsz_vld  = vld;
        rsz_data = d;
        out_rdy  = rdy;
        reset    = rst;
        do_push  = vld && (q.size() < DEPTH);
        do_pop   = rdy && (q.size() > 0);
        @(posedge clk);
        if (rst) begin
            q.delete();
            k      = 0;
            busy_m = 1'b0;
            done_m = 1'b0;
            for (int m = 0; m < 3; m++) fwd_m[m] = 1'b0;
        end else begin
            for (int m = 0; m < 3; m++) fwd_m[m] = do_pop && unit_done(m, k);
            done_m = do_pop && (k == NPIX - 1);
            if (do_push)
                busy_m = 1'b1;
            else if (do_pop && k == NPIX - 1)
                busy_m = 1'b0;
            if (do_pop) begin
                void'(q.pop_front());
                k = (k == NPIX - 1) ? 0 : k + 1;
            end
            if (do_push)
                q.push_back(d);
        end
    endtask

    task automatic clear_sums();
        for (int m = 0; m < 3; m++) begin
            fwd_sum[m]  = 0;
            done_sum[m] = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
    endtask

    initial begin
        reset    = 1'b1;
        rsz_vld  = 1'b0;
        rsz_data = '0;
        out_rdy  = 1'b0;
        q.delete();
        k      = 0;
        busy_m = 1'b0;
        done_m = 1'b0;
        for (int m = 0; m < 3; m++) fwd_m[m] = 1'b0;
        clear_sums();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int m = 0; m < 3; m++)
            check($sformatf("reset last m%0d", m), 32'(last_o[m]), 32'(0));
        step(1'b0, '0, 1'b0, 1'b1);

        // One frame of 0x10..0x17 with downstream always ready.
        clear_sums();
        for (int i = 0; i < NPIX; i++) step(1'b1, pxl_t'(24'h10 + i), 1'b1, 1'b0);
        idle(3);
        check("frame fwd PXL", 32'(fwd_sum[0]), 32'(8));
        check("frame fwd ROW", 32'(fwd_sum[1]), 32'(2));
        check("frame fwd COL", 32'(fwd_sum[2]), 32'(4));
        for (int m = 0; m < 3; m++)
            check($sformatf("frame done m%0d", m), 32'(done_sum[m]), 32'(1));

        // Downstream stall: 5 offered, 4 fit; then one pop while still offering.
        for (int i = 0; i < 5; i++) step(1'b1, pxl_t'(24'h10 + i), 1'b0, 1'b0);
        check("stall rdy", 32'(rdy_o[1]), 32'(0));
        step(1'b1, pxl_t'(24'h20), 1'b1, 1'b0);
        step(1'b1, pxl_t'(24'h20), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, pxl_t'(24'h21 + i), 1'b1, 1'b0);
        idle(6);

        // Reset mid-frame after three pops.
        for (int i = 0; i < 4; i++) step(1'b1, pxl_t'(24'h30 + i), 1'b1, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1);
        clear_sums();
        for (int i = 0; i < NPIX; i++) step(1'b1, pxl_t'(24'h40 + i), 1'b1, 1'b0);
        idle(3);
        check("post-reset fwd ROW", 32'(fwd_sum[1]), 32'(2));
        check("post-reset done", 32'(done_sum[1]), 32'(1));

        // Back-to-back frames.
        clear_sums();
        for (int i = 0; i < 2 * NPIX; i++) step(1'b1, pxl_t'(24'h50 + i), 1'b1, 1'b0);
        idle(3);
        check("b2b fwd ROW", 32'(fwd_sum[1]), 32'(4));
        check("b2b fwd PXL", 32'(fwd_sum[0]), 32'(16));
        check("b2b fwd COL", 32'(fwd_sum[2]), 32'(8));
        check("b2b done", 32'(done_sum[1]), 32'(2));

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) < 7, pxl_t'($urandom), $urandom_range(0, 9) < 6,
                 $urandom_range(0, 999) < 3);
        idle(8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
